data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port 32x8 Data_Memory between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/loader port.
- Arbitrates between the two, latches the winning request and sequences exactly one memory access per transaction.
- Returns a one-cycle ack and registered read data to the winner.
- Sits between the requesters and the Data_Memory ports (En, Address, Data_in, Data_out). All memory-side outputs are registered.

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 8, data width.
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_req  in  1  port 0 request; held high until r0_ack.
- r0_we  in  1  port 0 write (1) / read (0).
- r0_addr  in  ADDR_W  port 0 address.
- r0_wdata  in  DATA_W  port 0 write data.
- r0_ack  out  1  port 0 completion pulse.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack: same as port 0, for port 1.
- rdata  out  DATA_W  read data; valid in the ack cycle.
- owner  out  1  port id of the current or last transaction.
- busy  out  1  high while state is not IDLE.
- mem_en  out  1  drives Data_Memory En (write strobe).
- mem_addr  out  ADDR_W  drives Data_Memory Address.
- mem_din  out  DATA_W  drives Data_Memory Data_in.
- mem_dout  in  DATA_W  from Data_Memory Data_out (combinational read).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - r0_ack, r1_ack, mem_en, mem_addr, mem_din, rdata, owner and busy all go to 0.
  - last_grant is set to 1, so port 0 wins the first tie.
  - Effect is immediate, not clock-aligned.
- FSM states: IDLE, ACCESS, ACK, with transitions as below.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, select that port.
  - If both are high with FIXED_PRIO=0, select the port that is not last_grant. With FIXED_PRIO=1, select port 0.
  - On the selecting edge: latch we/addr/wdata into mem_en<=we, mem_addr<=addr, mem_din<=wdata; set owner<=port and busy<=1; go to ACCESS.
- ACCESS (exactly one cycle):
  - Memory outputs are stable. Data_Memory writes at the edge that ends ACCESS when mem_en=1.
  - On that edge: if the latched op is a read, rdata<=mem_dout; on a write, rdata is unchanged.
  - Also on that edge: mem_en<=0, assert owner's ack<=1, last_grant<=owner, go to ACK.
- ACK (one cycle):
  - Owner's ack is high; rdata is valid.
  - On exit: ack<=0, busy<=0, go to IDLE. mem_addr and mem_din hold their values.
- Latency: req sampled in IDLE -> ack high 2 cycles later. Throughput is one transaction per 3 cycles; there is no pipelining.
- Requester protocol:
  - Deassert req on the edge that samples ack=1. It is then low in the following IDLE, so no duplicate access occurs.
  - Req held one extra cycle is treated as a new transaction.
- Changes to the granted port's req/we/addr/wdata after the grant are ignored, because the request is latched.
- Req dropped before ack: the transaction still completes and ack still pulses.
- A requester that loses arbitration keeps req high and is served in the next IDLE. With round-robin, a port waits at most 1 transaction.
- mem_en is high for exactly one clock per write and never on a read.
- Reset mid-ACCESS: mem_en drops immediately, no write is guaranteed, no ack is issued, and the FSM returns to IDLE.
- Widths: all address/data paths are pass-through with no arithmetic. owner and last_grant are 1 bit each.

Decomposition:
- Package data_mem_arb_pkg:
  - state enum {IDLE, ACCESS, ACK};
  - port-id constants PORT_CPU=0, PORT_DBG=1;
  - ACK_LATENCY=2.
- Sub-module rr_arbiter_2:
  - Combinational pick from req[1:0], last_grant and FIXED_PRIO.
  - Produces grant_valid and grant_id.
  - The top level owns the FSM and all registers.

Test Plan:
- Reset: drive reset=0 mid-simulation -> all outputs 0 immediately; after release, busy=0 and the state is IDLE.
- Port 0 read of 0x1B (memory reset content FF) -> r0_ack high 2 cycles after req is sampled, rdata=FF, mem_en never high, r1_ack stays 0.
- Port 1 write 0x1C=5A:
  - mem_en high for exactly one cycle with mem_addr=1C and mem_din=5A;
  - r1_ack pulses once;
  - a following port 0 read of 0x1C returns rdata=5A.
- Both req held continuously, FIXED_PRIO=0 -> ack order r0, r1, r0, r1, with one ack every 3 cycles. With FIXED_PRIO=1 -> only r0 is acked while r0_req is held.
- Reset asserted during ACCESS of a write to 0x1A -> mem_en falls asynchronously, no ack issued, busy=0, next transaction proceeds normally.
- Granted port changes r0_addr from 1A to 1B one cycle after grant -> access still targets 1A; rdata=00.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the Data_Memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Edges from the cycle req is first presented to the cycle ack is high.
    localparam int ACK_LATENCY = 2;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester picker: a lone requester wins outright. On a tie the port
// that did not win last time is chosen, unless FIXED_PRIO pins the CPU port.
module rr_arbiter_2
    import data_mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // Pure combinational pick; the caller registers the result.
    always_comb begin
        grant_valid = |req;
        grant_id    = PORT_CPU;
        case (req)
            2'b10:   grant_id = PORT_DBG;
            2'b11:   grant_id = (FIXED_PRIO != 0) ? PORT_CPU : ~last_grant;
            default: grant_id = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port Data_Memory between the CPU load/store port (0)
// and the debug/loader port (1). One access per transaction, sequenced
// IDLE -> ACCESS -> ACK; every memory-side output comes from a flop.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              owner,
    output logic              busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            state, state_nxt;
    logic              last_grant;
    logic              grant_valid, grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter_2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .req        ({r1_req, r0_req}),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    // Steer the winning port's request onto the latch inputs.
    always_comb begin
        sel_we    = r0_we;
        sel_addr  = r0_addr;
        sel_wdata = r0_wdata;
        if (grant_id == PORT_DBG) begin
            sel_we    = r1_we;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: wait for a grant, then one ACCESS and one ACK cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, memory drive, read capture and ack generation.
    // last_grant resets to DBG so the CPU port wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            rdata      <= '0;
            owner      <= PORT_CPU;
            busy       <= 1'b0;
            last_grant <= PORT_DBG;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_en   <= sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_wdata;
                        owner    <= grant_id;
                        busy     <= 1'b1;
                    end
                end
                ACCESS: begin
                    // mem_en still holds the latched op: low means a read.
                    if (!mem_en) rdata <= mem_dout;
                    mem_en     <= 1'b0;
                    r0_ack     <= (owner == PORT_CPU);
                    r1_ack     <= (owner == PORT_DBG);
                    last_grant <= owner;
                end
                ACK: begin
                    r0_ack <= 1'b0;
                    r1_ack <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    r0_ack <= 1'b0;
                    r1_ack <= 1'b0;
                    mem_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a 32x8 Data_Memory model.
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    logic       clock, reset;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [4:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_ack, r1_ack, owner, busy, mem_en;
    logic [7:0] rdata, mem_din, mem_dout;
    logic [4:0] mem_addr;

    // second instance, fixed priority, fed its own requests
    logic       f_r0_req, f_r1_req, f_r0_ack, f_r1_ack, f_owner, f_busy, f_mem_en;
    logic [7:0] f_rdata, f_mem_din, f_mem_dout;
    logic [4:0] f_mem_addr;

    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];

    typedef struct {
        logic       port;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_err = 0, en_cnt = 0;

    data_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(0)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
        .rdata(rdata), .owner(owner), .busy(busy),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    data_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset),
        .r0_req(f_r0_req), .r0_we(1'b0), .r0_addr(5'h02), .r0_wdata(8'h00), .r0_ack(f_r0_ack),
        .r1_req(f_r1_req), .r1_we(1'b0), .r1_addr(5'h03), .r1_wdata(8'h00), .r1_ack(f_r1_ack),
        .rdata(f_rdata), .owner(f_owner), .busy(f_busy),
        .mem_en(f_mem_en), .mem_addr(f_mem_addr), .mem_din(f_mem_din), .mem_dout(f_mem_dout)
    );

    assign f_mem_dout = {3'b000, f_mem_addr};
    assign mem_dout   = mem[mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory model: write on the rising edge while En is high
    always @(posedge clock) if (mem_en) mem[mem_addr] <= mem_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic we, input logic [4:0] addr,
                            input logic [7:0] wdata);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
        e.rdata = ref_mem[addr];
        if (we) ref_mem[addr] = wdata;
        sb.push_back(e);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (reset) begin
            if (r0_ack && r1_ack) chk("dual_ack", 1, 0);
            if (r0_ack || r1_ack) begin
                if (sb.size() == 0) chk("spur_ack", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_port", r1_ack, e.port);
                    chk("owner", owner, e.port);
                    if (!e.we) chk("rdata", rdata, e.rdata);
                end
            end
            if (mem_en) begin
                en_cnt++;
                if (sb.size() == 0) chk("spur_en", 1, 0);
                else begin
                    chk("wr_addr", mem_addr, sb[0].addr);
                    chk("wr_data", mem_din, sb[0].wdata);
                end
            end
        end
    end

    task automatic do_txn(input logic port, input logic we, input logic [4:0] addr,
                          input logic [7:0] wdata, input bit chg);
        int lat, en0;
        en0 = en_cnt;
        @(posedge clock); #1;
        if (port) begin r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1; end
        else      begin r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1; end
        push_exp(port, we, addr, wdata);
        lat = 0;
        while (!(port ? r1_ack : r0_ack) && lat < 20) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 1) begin
                chk("busy_on", busy, 1);
                if (chg) begin
                    if (port) r1_addr = addr ^ 5'h01;
                    else      r0_addr = addr ^ 5'h01;
                end
            end
        end
        chk("latency", lat, ACK_LATENCY);
        if (chg) chk("addr_hold", mem_addr, addr);
        @(posedge clock); #1;
        r0_req = 1'b0; r1_req = 1'b0;
        chk("busy_off", busy, 0);
        chk("en_pulses", en_cnt - en0, {31'd0, we});
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_r0_ack"}, r0_ack, 0);
        chk({tag, "_r1_ack"}, r1_ack, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_din"}, mem_din, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int t_ack[4];
        int n_ack, f0, f1;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'hFF;
            ref_mem[i] = 8'hFF;
        end
        mem[5'h1A] = 8'h00;
        ref_mem[5'h1A] = 8'h00;
        reset = 1'b0;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        f_r0_req = 0; f_r1_req = 0;

        #3;
        chk_reset_outs("por");
        #9 reset = 1'b1;
        #1 chk("busy_after_rst", busy, 0);

        // single transactions
        do_txn(PORT_CPU, 1'b0, 5'h1B, 8'h00, 1'b0);
        do_txn(PORT_DBG, 1'b1, 5'h1C, 8'h5A, 1'b0);
        do_txn(PORT_CPU, 1'b0, 5'h1C, 8'h00, 1'b0);

        // fresh reset so the first tie goes to port 0
        @(posedge clock); #2 reset = 1'b0;
        #2 reset = 1'b1;

        // both ports held: round-robin alternates, fixed priority starves port 1
        @(posedge clock); #1;
        r0_we = 0; r0_addr = 5'h1B; r1_we = 0; r1_addr = 5'h1C;
        r0_req = 1'b1; r1_req = 1'b1;
        f_r0_req = 1'b1; f_r1_req = 1'b1;
        push_exp(PORT_CPU, 1'b0, 5'h1B, 8'h00);
        push_exp(PORT_DBG, 1'b0, 5'h1C, 8'h00);
        push_exp(PORT_CPU, 1'b0, 5'h1B, 8'h00);
        push_exp(PORT_DBG, 1'b0, 5'h1C, 8'h00);
        n_ack = 0; f0 = 0; f1 = 0;
        for (int c = 1; c <= 20 && n_ack < 4; c++) begin
            @(posedge clock); #1;
            if (f_r0_ack) f0++;
            if (f_r1_ack) f1++;
            if (r0_ack || r1_ack) begin
                t_ack[n_ack] = c;
                n_ack++;
            end
        end
        chk("rr_ack_count", n_ack, 4);
        for (int i = 1; i < 4; i++) chk("rr_gap", t_ack[i] - t_ack[i-1], 3);
        chk("fp_r0_acks", f0, 4);
        chk("fp_r1_acks", f1, 0);
        @(posedge clock); #1;
        r0_req = 0; r1_req = 0; f_r0_req = 0; f_r1_req = 0;

        // reset during ACCESS of a write to 1A
        @(posedge clock); #1;
        r1_we = 1'b1; r1_addr = 5'h1A; r1_wdata = 8'h00; r1_req = 1'b1;
        @(posedge clock);
        #1 chk("abort_en_before", mem_en, 1);
        #1 reset = 1'b0;
        #1 chk_reset_outs("abort");
        r1_req = 1'b0; r1_we = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 chk("abort_idle", busy, 0);

        // granted port moves its address after the grant: 1A is still read
        do_txn(PORT_CPU, 1'b0, 5'h1A, 8'h00, 1'b1);

        repeat (2) @(posedge clock);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
